// File: rtl/ps2_kbd_fifo_if.sv
// CPU-side status/pop interface of the PS/2 keyboard receiver.
// The slave modport belongs to the receiver. The master modport belongs to the reader.
interface ps2_kbd_fifo_if #(
   parameter int CNT_W = 5
);
   logic             rdn;
   logic             clr_err;
   logic [7:0]       data;
   logic             ready;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             parity_err;
   logic             frame_err;

   modport master (
      output rdn, clr_err,
      input  data, ready, count, overflow, parity_err, frame_err
   );

   modport slave (
      input  rdn, clr_err,
      output data, ready, count, overflow, parity_err, frame_err
   );
endinterface

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver. It checks parity, the stop bit and an inter-bit timeout.
// Good scan codes go into a DEPTH-entry FIFO, and the module keeps sticky error flags.
module ps2_kbd_fifo #(
   parameter int DEPTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 20000,
   parameter int CNT_W       = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   ps2_kbd_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   r_fe;
   logic                   r_bit;

   logic [1:0]             r_state;
   logic [2:0]             r_bitcnt;
   logic [7:0]             r_shift;
   logic                   r_par;
   logic [TW-1:0]          r_tmo;

   logic [7:0]             r_mem [DEPTH];
   logic [AW-1:0]          r_wptr;
   logic [AW-1:0]          r_rptr;
   logic [CNT_W-1:0]       r_count;
   logic                   r_ovf;
   logic                   r_perr;
   logic                   r_ferr;

   logic w_abort;
   logic w_stop_fe;
   logic w_par_ok;
   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_wr;
   logic w_ovf_ev;
   logic w_perr_ev;
   logic w_ferr_ev;

   // The synchroniser idles at 1, which is the PS/2 idle level. The data bit is delayed so it lines up with r_fe.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
         r_fe       <= 1'b0;
         r_bit      <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
         r_fe       <= r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
         r_bit      <= r_dat_sync[SYNC_STAGES-1];
      end
   end

   always_comb begin
      w_abort   = !r_fe && (r_state != S_IDLE) && (r_tmo == TW'(TIMEOUT_CYC - 1));
      w_stop_fe = r_fe && (r_state == S_STOP);
      w_par_ok  = ^{r_shift, r_par};
      w_push    = w_stop_fe && r_bit && w_par_ok;
      w_perr_ev = w_stop_fe && r_bit && !w_par_ok;
      w_ferr_ev = (w_stop_fe && !r_bit) || w_abort;
      w_pop     = !bus.rdn && (r_count != '0);
      w_full    = (r_count == CNT_W'(DEPTH));
      w_wr      = w_push && (!w_full || w_pop);
      w_ovf_ev  = w_push && w_full && !w_pop;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state  <= S_IDLE;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_tmo    <= '0;
      end else begin
         if (r_fe || (r_state == S_IDLE) || w_abort)
            r_tmo <= '0;
         else
            r_tmo <= r_tmo + 1'b1;

         if (w_abort) begin
            r_state <= S_IDLE;
         end else if (r_fe) begin
            case (r_state)
               S_IDLE: begin
                  // A falling edge with data high is a glitch, not a start bit.
                  if (!r_bit) begin
                     r_state  <= S_DATA;
                     r_bitcnt <= '0;
                  end
               end
               S_DATA: begin
                  r_shift  <= {r_bit, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == 3'd7)
                     r_state <= S_PARITY;
               end
               S_PARITY: begin
                  r_par   <= r_bit;
                  r_state <= S_STOP;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wptr] <= r_shift;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // If an error event and clr_err happen in the same cycle, the flag stays set.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_ovf  <= 1'b0;
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_ovf  <= w_ovf_ev  | (r_ovf  & ~bus.clr_err);
         r_perr <= w_perr_ev | (r_perr & ~bus.clr_err);
         r_ferr <= w_ferr_ev | (r_ferr & ~bus.clr_err);
      end
   end

   assign bus.data       = (r_count != '0) ? r_mem[r_rptr] : 8'h00;
   assign bus.ready      = (r_count != '0);
   assign bus.count      = r_count;
   assign bus.overflow   = r_ovf;
   assign bus.parity_err = r_perr;
   assign bus.frame_err  = r_ferr;
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Scoreboard bench for ps2_kbd_fifo with DEPTH=4 and TIMEOUT_CYC=100.
module tb_ps2_kbd_fifo;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;
   localparam int HALF  = 10;

   logic clk = 1'b0;
   logic clrn;
   logic ps2_clk;
   logic ps2_data;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [7:0]  exp_q [$];

   ps2_kbd_fifo_if #(.CNT_W(CNT_W)) bus ();

   ps2_kbd_fifo #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (2),
      .TIMEOUT_CYC (100),
      .CNT_W       (CNT_W)
   ) dut (
      .clk      (clk),
      .clrn     (clrn),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   // pop_here pulls rdn low for the one cycle in which the DUT acts on this bit's falling edge.
   task automatic ps2_bit(input logic b, input bit pop_here);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_here) begin
         repeat (3) @(negedge clk);
         bus.rdn = 1'b0;
         @(negedge clk);
         bus.rdn = 1'b1;
         repeat (HALF - 4) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                             input int unsigned nbits, input bit pop_at_stop);
      logic [10:0] f;
      f = {stop, par, b, 1'b0};
      for (int unsigned i = 0; i < nbits; i++)
         ps2_bit(f[i], pop_at_stop && (i == 10));
      ps2_data = 1'b1;
      repeat (HALF + 4) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, odd_par(b), 1'b1, 11, 1'b0);
      if (exp_q.size() < DEPTH)
         exp_q.push_back(b);
   endtask

   task automatic pulse_clr_err();
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
      n_checks++;
      if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
      n_checks++;
      if (bus.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.data); end
      n_checks++;
      if ({bus.overflow, bus.parity_err, bus.frame_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.overflow, bus.parity_err, bus.frame_err});
      end
   endtask

   task automatic test_single();
      send_good(8'h1C);
      n_checks++;
      if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", bus.ready); end
      n_checks++;
      if (bus.data !== exp_q[0]) begin n_fail++; $display("FAIL single_data: got %h expected %h", bus.data, exp_q[0]); end
      n_checks++;
      if (bus.count !== CNT_W'(exp_q.size())) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", bus.count, exp_q.size()); end
      n_checks++;
      if ({bus.overflow, bus.parity_err, bus.frame_err} !== 3'b000) begin
         n_fail++; $display("FAIL single_flags: got %b expected 000", {bus.overflow, bus.parity_err, bus.frame_err});
      end
      bus.rdn = 1'b0;
      @(negedge clk);
      bus.rdn = 1'b1;
      exp_q.pop_front();
      n_checks++;
      if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL single_pop_ready: got %b expected 0", bus.ready); end
      n_checks++;
      if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL single_pop_count: got %0d expected 0", bus.count); end
   endtask

   task automatic test_burst();
      logic [7:0] pats [4];
      pats = '{8'hF0, 8'h1C, 8'h00, 8'hFF};
      for (int unsigned i = 0; i < 4; i++)
         send_good(pats[i]);
      n_checks++;
      if (bus.count !== CNT_W'(exp_q.size())) begin n_fail++; $display("FAIL burst_count: got %0d expected %0d", bus.count, exp_q.size()); end
      for (int unsigned i = 0; i < DEPTH && exp_q.size() > 0; i++) begin
         n_checks++;
         if (bus.data !== exp_q[0]) begin n_fail++; $display("FAIL burst_data: got %h expected %h", bus.data, exp_q[0]); end
         bus.rdn = 1'b0;
         @(negedge clk);
         bus.rdn = 1'b1;
         exp_q.pop_front();
      end
      n_checks++;
      if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL burst_empty: got %b expected 0", bus.ready); end
   endtask

   task automatic test_overflow();
      logic [7:0] pats [5];
      pats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int unsigned i = 0; i < 5; i++)
         send_good(pats[i]);
      n_checks++;
      if (bus.count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", bus.count, DEPTH); end
      n_checks++;
      if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
      pulse_clr_err();
      n_checks++;
      if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
      for (int unsigned i = 0; i < DEPTH && exp_q.size() > 0; i++) begin
         n_checks++;
         if (bus.data !== exp_q[0]) begin n_fail++; $display("FAIL ovf_data: got %h expected %h", bus.data, exp_q[0]); end
         bus.rdn = 1'b0;
         @(negedge clk);
         bus.rdn = 1'b1;
         exp_q.pop_front();
      end
      n_checks++;
      if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 0", bus.count); end
   endtask

   task automatic test_errors();
      send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
      n_checks++;
      if ({bus.parity_err, bus.frame_err} !== 2'b10) begin
         n_fail++; $display("FAIL parity_flags: got %b expected 10", {bus.parity_err, bus.frame_err});
      end
      n_checks++;
      if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL parity_count: got %0d expected 0", bus.count); end
      pulse_clr_err();
      send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
      n_checks++;
      if ({bus.parity_err, bus.frame_err} !== 2'b01) begin
         n_fail++; $display("FAIL stop_flags: got %b expected 01", {bus.parity_err, bus.frame_err});
      end
      n_checks++;
      if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL stop_count: got %0d expected 0", bus.count); end
      pulse_clr_err();
      send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
      n_checks++;
      if ({bus.parity_err, bus.frame_err} !== 2'b01) begin
         n_fail++; $display("FAIL both_bad_flags: got %b expected 01", {bus.parity_err, bus.frame_err});
      end
      pulse_clr_err();
      n_checks++;
      if ({bus.parity_err, bus.frame_err} !== 2'b00) begin
         n_fail++; $display("FAIL err_clear: got %b expected 00", {bus.parity_err, bus.frame_err});
      end
   endtask

   task automatic test_timeout();
      int unsigned waited;
      send_frame(8'h5A, 1'b1, 1'b1, 5, 1'b0);
      n_checks++;
      if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", bus.frame_err); end
      waited = 0;
      while (bus.frame_err !== 1'b1 && waited < 120) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (waited > 100) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles expected <= 100", waited); end
      n_checks++;
      if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL tmo_count: got %0d expected 0", bus.count); end
      pulse_clr_err();
      send_good(8'h5A);
      n_checks++;
      if (bus.data !== 8'h5A || bus.count !== CNT_W'(1)) begin
         n_fail++; $display("FAIL tmo_recover: got %h/%0d expected 5a/1", bus.data, bus.count);
      end
      n_checks++;
      if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_recover_flag: got %b expected 0", bus.frame_err); end
      bus.rdn = 1'b0;
      @(negedge clk);
      bus.rdn = 1'b1;
      exp_q.pop_front();
   endtask

   task automatic test_full_pop();
      logic [7:0] pats [4];
      pats = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      for (int unsigned i = 0; i < 4; i++)
         send_good(pats[i]);
      send_frame(8'hB5, odd_par(8'hB5), 1'b1, 11, 1'b1);
      exp_q.pop_front();
      exp_q.push_back(8'hB5);
      n_checks++;
      if (bus.count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL fullpop_count: got %0d expected %0d", bus.count, DEPTH); end
      n_checks++;
      if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b expected 0", bus.overflow); end
      for (int unsigned i = 0; i < DEPTH && exp_q.size() > 0; i++) begin
         n_checks++;
         if (bus.data !== exp_q[0]) begin n_fail++; $display("FAIL fullpop_data: got %h expected %h", bus.data, exp_q[0]); end
         bus.rdn = 1'b0;
         @(negedge clk);
         bus.rdn = 1'b1;
         exp_q.pop_front();
      end
   endtask

   task automatic test_reset_midframe();
      send_good(8'h77);
      send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, 4, 1'b0);
      clrn = 1'b0;
      exp_q.delete();
      @(negedge clk);
      n_checks++;
      if ({bus.ready, bus.count, bus.data} !== {1'b0, CNT_W'(0), 8'h00}) begin
         n_fail++; $display("FAIL midrst_outputs: got %b/%0d/%h expected 0/0/00", bus.ready, bus.count, bus.data);
      end
      n_checks++;
      if ({bus.overflow, bus.parity_err, bus.frame_err} !== 3'b000) begin
         n_fail++; $display("FAIL midrst_flags: got %b expected 000", {bus.overflow, bus.parity_err, bus.frame_err});
      end
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      send_good(8'h5A);
      n_checks++;
      if (bus.data !== 8'h5A || bus.count !== CNT_W'(1)) begin
         n_fail++; $display("FAIL midrst_recover: got %h/%0d expected 5a/1", bus.data, bus.count);
      end
      n_checks++;
      if ({bus.parity_err, bus.frame_err} !== 2'b00) begin
         n_fail++; $display("FAIL midrst_recover_flags: got %b expected 00", {bus.parity_err, bus.frame_err});
      end
   endtask

   initial begin
      clrn        = 1'b0;
      ps2_clk     = 1'b1;
      ps2_data    = 1'b1;
      bus.rdn     = 1'b1;
      bus.clr_err = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      test_single();
      test_burst();
      test_overflow();
      test_errors();
      test_timeout();
      test_full_pop();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_kbd_fifo.md
Name: ps2_kbd_fifo

Overview:
- Parametrised PS/2 keyboard receiver with a configurable-depth scan-code FIFO.
- Successor to the fixed 8-entry ps2_kbd that sits beside the cpu and feeds kb_data/kb_ready.
- Adds parameterised synchroniser depth, odd-parity and stop-bit checking, and an inter-bit timeout that aborts a stalled frame.
- Adds sticky error flags and a FIFO occupancy count that the cpu can read for status.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- SYNC_STAGES, 2, flops on ps2_clk/ps2_data before edge detection; must be at least 2.
- TIMEOUT_CYC, 20000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted.
- CNT_W, $clog2(DEPTH)+1, width of the count output.

Ports:
- clk  input  1  system clock
- clrn  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock, asynchronous to clk
- ps2_data  input  1  raw PS/2 data, asynchronous to clk
- rdn  input  1  active-low pop strobe, level-sensitive
- clr_err  input  1  active-high; clears the sticky error flags
- data  output  8  FIFO head byte; valid while ready=1
- ready  output  1  FIFO non-empty
- count  output  CNT_W  current FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky; a byte was dropped because the FIFO was full
- parity_err  output  1  sticky; a frame with bad odd parity was discarded
- frame_err  output  1  sticky; a frame was discarded for stop bit = 0 or for timeout

Behaviour:
- Reset: clock and reset are fixed as decided. clrn low asynchronously clears all state; clrn is the only reset.
  - FSM goes to IDLE; FIFO pointers, count, shift register and timeout counter go to 0.
  - ready=0, count=0, data=8'h00, and all error flags are 0.
  - Synchroniser flops reset to 1, the PS/2 idle level.
  - Asserting clrn mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data each pass through SYNC_STAGES flops.
  - A falling edge (fe) is registered previous-sync=1, current-sync=0.
  - fe is a 1-cycle pulse, SYNC_STAGES+1 clk cycles after the pin falls.
  - Data is sampled from the synchronised ps2_data in the cycle fe=1.
- FSM states:
  - IDLE: on fe, if data=0 (start bit) go to DATA with bit index=0. If data=1, treat as a glitch: stay in IDLE, no error.
  - DATA: on each fe, shift in the data bit LSB first. After the 8th bit go to PARITY.
  - PARITY: on fe, capture the parity bit and go to STOP.
  - STOP: on fe, check the stop bit and parity, then always return to IDLE.
    - stop=1 and XOR(8 data bits, parity bit)=1: push the byte.
    - stop=0: discard the byte, set frame_err.
    - stop=1 and parity wrong: discard the byte, set parity_err.
    - If both checks fail, set only frame_err.
- Timeout: the counter clears on every fe and in IDLE, and increments in every other state.
  - When it reaches TIMEOUT_CYC-1, the FSM goes to IDLE, the partial byte is discarded and frame_err is set.
- FIFO push: the write occurs on the clk edge that ends the STOP-state fe cycle.
  - ready and count reflect the new byte from the next cycle.
  - If full and no pop occurs that cycle, the byte is dropped, overflow is set and the FIFO is unchanged.
- FIFO pop: on each clk edge where rdn=0 and count>0, the read pointer advances and count decrements.
  - One entry is popped per cycle while rdn stays low; rdn=0 when empty is ignored.
  - data is the registered or combinational head at the read pointer and must be stable while ready=1 and no pop occurs.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because a slot is freed that cycle, and overflow is not set.
  - When empty, the pop is ignored and the push proceeds, so count=1.
- Pointers: log2(DEPTH)-bit, wrapping naturally modulo DEPTH; count saturates neither at 0 nor at DEPTH by construction.
- Error flags: clr_err=1 clears all three flags on the next edge. If an error event coincides with clr_err, the flag ends up set (set wins).

Test Plan:
- Single frame: send 0x1C with parity=0 and stop=1 -> ready=1, data=8'h1C, count=1, no flags; then rdn low for 1 cycle -> ready=0, count=0.
- Burst: send 0xF0 (parity=1) then 0x1C; pop twice -> data 8'hF0 then 8'h1C in order; also sweep data byte/parity pairs for 0x00 (parity=1) and 0xFF (parity=1).
- Overflow: DEPTH=4; send 5 frames with no pops -> count=4, overflow=1, FIFO holds frames 1-4; clr_err -> overflow=0.
- Parity and stop errors: send 0x1C with parity=1 -> parity_err=1, count unchanged; send a frame with stop=0 -> frame_err=1, no push.
- Timeout and recovery: TIMEOUT_CYC=100; stop ps2_clk after 4 data bits -> frame_err=1 within 100 cycles and FSM in IDLE; the next good frame 0x5A is received correctly.
- Full plus simultaneous pop, and reset mid-frame:
  - FIFO full, hold rdn=0 during the stop-bit fe -> count stays DEPTH, overflow=0, the new byte is at the tail.
  - clrn low mid-frame -> all outputs 0; the next frame is received cleanly.
